// File: rtl/laser_frame_sequencer.sv
// laser_frame_sequencer
//   Upstream feeder for the laser two-circle search core. It collects one
//   frame of NPTS target points from a valid/ready stream and then pulses
//   the core reset for one cycle. Next it replays the frame to the core at
//   one point per cycle, waits for the core's DONE (with a timeout watchdog)
//   and presents the two circle centres on a valid/ready result channel.
//
// Ports
//   CLK, RST              clock, synchronous active-high reset
//   IN_VALID/IN_READY     point input handshake, point = {IN_Y, IN_X}
//   CORE_RST              registered reset to the core
//   CORE_X/CORE_Y         replayed point stream to the core
//   CORE_DONE, CORE_C*    core result strobe and circle centres
//   OUT_VALID/OUT_READY   result handshake
//   OUT_C*                captured centres (0 on timeout)
//   OUT_ERR               1 = core timed out
//   BUSY                  high in every state other than COLLECT
module laser_frame_sequencer #(
    parameter int NPTS    = 40,
    parameter int IDX_W   = 6,
    parameter int TIMEOUT = 40000,
    parameter int TO_W    = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       IN_VALID,
    output logic       IN_READY,
    input  logic [3:0] IN_X,
    input  logic [3:0] IN_Y,
    output logic       CORE_RST,
    output logic [3:0] CORE_X,
    output logic [3:0] CORE_Y,
    input  logic       CORE_DONE,
    input  logic [3:0] CORE_C1X,
    input  logic [3:0] CORE_C1Y,
    input  logic [3:0] CORE_C2X,
    input  logic [3:0] CORE_C2Y,
    output logic       OUT_VALID,
    input  logic       OUT_READY,
    output logic [3:0] OUT_C1X,
    output logic [3:0] OUT_C1Y,
    output logic [3:0] OUT_C2X,
    output logic [3:0] OUT_C2Y,
    output logic       OUT_ERR,
    output logic       BUSY
);

    typedef enum logic [2:0] {
        COLLECT    = 3'd0,
        CORE_RESET = 3'd1,
        STREAM     = 3'd2,
        WAIT_DONE  = 3'd3,
        PRESENT    = 3'd4
    } state_t;

    state_t            state_q;
    logic [IDX_W-1:0]  count_q;
    logic [IDX_W-1:0]  idx_q;
    logic [TO_W-1:0]   to_cnt_q;
    logic [7:0]        pts_q [NPTS];
    logic              in_ready_q;
    logic              core_rst_q;
    logic [3:0]        core_x_q;
    logic [3:0]        core_y_q;
    logic              out_valid_q;
    logic              out_err_q;
    logic [15:0]       out_c_q;
    logic              busy_q;
    logic              accept_s;

    assign accept_s = IN_VALID && in_ready_q && (state_q == COLLECT);

    // Point buffer: frame data only, so it is not cleared by reset; count_q
    // alone decides which entries are meaningful.
    always_ff @(posedge CLK) begin
        if (!RST && accept_s) begin
            pts_q[count_q] <= {IN_Y, IN_X};
        end
    end

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= COLLECT;
            count_q     <= {IDX_W{1'b0}};
            idx_q       <= {IDX_W{1'b0}};
            to_cnt_q    <= {TO_W{1'b0}};
            in_ready_q  <= 1'b0;
            core_rst_q  <= 1'b1;
            core_x_q    <= 4'd0;
            core_y_q    <= 4'd0;
            out_valid_q <= 1'b0;
            out_err_q   <= 1'b0;
            out_c_q     <= 16'd0;
            busy_q      <= 1'b0;
        end else begin
            // Core reset is a single-cycle pulse unless a branch re-asserts it.
            core_rst_q <= 1'b0;
            case (state_q)
                COLLECT: begin
                    in_ready_q <= 1'b1;
                    if (accept_s) begin
                        count_q <= count_q + IDX_W'(1);
                        // Last point: drop ready now so nothing is overaccepted.
                        if (count_q == IDX_W'(NPTS - 1)) begin
                            state_q    <= CORE_RESET;
                            in_ready_q <= 1'b0;
                            core_rst_q <= 1'b1;
                            busy_q     <= 1'b1;
                        end
                    end
                end
                CORE_RESET: begin
                    // Point 0 goes out in the first cycle CORE_RST is low.
                    state_q  <= STREAM;
                    idx_q    <= {IDX_W{1'b0}};
                    core_x_q <= pts_q[0][3:0];
                    core_y_q <= pts_q[0][7:4];
                end
                STREAM: begin
                    if (idx_q == IDX_W'(NPTS - 1)) begin
                        state_q  <= WAIT_DONE;
                        core_x_q <= 4'd0;
                        core_y_q <= 4'd0;
                        to_cnt_q <= {TO_W{1'b0}};
                    end else begin
                        idx_q    <= idx_q + IDX_W'(1);
                        core_x_q <= pts_q[idx_q + IDX_W'(1)][3:0];
                        core_y_q <= pts_q[idx_q + IDX_W'(1)][7:4];
                    end
                end
                WAIT_DONE: begin
                    // DONE takes priority over a timeout in the same cycle.
                    if (CORE_DONE) begin
                        out_c_q     <= {CORE_C1X, CORE_C1Y, CORE_C2X, CORE_C2Y};
                        out_err_q   <= 1'b0;
                        out_valid_q <= 1'b1;
                        state_q     <= PRESENT;
                    end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
                        out_c_q     <= 16'd0;
                        out_err_q   <= 1'b1;
                        out_valid_q <= 1'b1;
                        state_q     <= PRESENT;
                    end else begin
                        to_cnt_q <= to_cnt_q + TO_W'(1);
                    end
                end
                PRESENT: begin
                    if (OUT_READY) begin
                        // Park the core while the next frame is collected.
                        out_valid_q <= 1'b0;
                        count_q     <= {IDX_W{1'b0}};
                        core_rst_q  <= 1'b1;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= COLLECT;
                    end else begin
                        out_valid_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= COLLECT;
                    count_q     <= {IDX_W{1'b0}};
                    in_ready_q  <= 1'b0;
                    core_rst_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign IN_READY  = in_ready_q;
    assign CORE_RST  = core_rst_q;
    assign CORE_X    = core_x_q;
    assign CORE_Y    = core_y_q;
    assign OUT_VALID = out_valid_q;
    assign OUT_ERR   = out_err_q;
    assign OUT_C1X   = out_c_q[15:12];
    assign OUT_C1Y   = out_c_q[11:8];
    assign OUT_C2X   = out_c_q[7:4];
    assign OUT_C2Y   = out_c_q[3:0];
    assign BUSY      = busy_q;

endmodule

// File: tb/tb_laser_frame_sequencer.sv
module tb_laser_frame_sequencer;
    localparam int NPTS    = 40;
    localparam int TIMEOUT = 50;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       IN_VALID = 1'b0;
    logic       IN_READY;
    logic [3:0] IN_X = 4'd0, IN_Y = 4'd0;
    logic       CORE_RST;
    logic [3:0] CORE_X, CORE_Y;
    logic       CORE_DONE = 1'b0;
    logic [3:0] CORE_C1X = 4'd0, CORE_C1Y = 4'd0, CORE_C2X = 4'd0, CORE_C2Y = 4'd0;
    logic       OUT_VALID;
    logic       OUT_READY = 1'b0;
    logic [3:0] OUT_C1X, OUT_C1Y, OUT_C2X, OUT_C2Y;
    logic       OUT_ERR;
    logic       BUSY;

    laser_frame_sequencer #(.NPTS(NPTS), .IDX_W(6), .TIMEOUT(TIMEOUT), .TO_W(16)) dut (
        .CLK(CLK), .RST(RST),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_X(IN_X), .IN_Y(IN_Y),
        .CORE_RST(CORE_RST), .CORE_X(CORE_X), .CORE_Y(CORE_Y),
        .CORE_DONE(CORE_DONE), .CORE_C1X(CORE_C1X), .CORE_C1Y(CORE_C1Y),
        .CORE_C2X(CORE_C2X), .CORE_C2Y(CORE_C2Y),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .OUT_C1X(OUT_C1X), .OUT_C1Y(OUT_C1Y), .OUT_C2X(OUT_C2X), .OUT_C2Y(OUT_C2Y),
        .OUT_ERR(OUT_ERR), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int failures = 0;

    // Reference model: the frame as sent, and the result the core model produced.
    logic [3:0]  px [NPTS];
    logic [3:0]  py [NPTS];
    logic [15:0] exp_res;
    logic        exp_err;

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic random_frame;
        for (int k = 0; k < NPTS; k++) begin
            px[k] = 4'($urandom);
            py[k] = 4'($urandom);
        end
    endtask

    task automatic test_reset;
        RST = 1'b1; IN_VALID = 1'b0; CORE_DONE = 1'b0; OUT_READY = 1'b0;
        tick; tick;
        checks++;
        if ({IN_READY, CORE_RST, OUT_VALID, OUT_ERR, BUSY} !== 5'b01000) begin
            failures++;
            $display("FAIL reset_flags: got %b want 01000", {IN_READY, CORE_RST, OUT_VALID, OUT_ERR, BUSY});
        end
        checks++;
        if ({CORE_X, CORE_Y, OUT_C1X, OUT_C1Y, OUT_C2X, OUT_C2Y} !== 24'h000000) begin
            failures++;
            $display("FAIL reset_data: got %h want 000000", {CORE_X, CORE_Y, OUT_C1X, OUT_C1Y, OUT_C2X, OUT_C2Y});
        end
        RST = 1'b0;
        tick;
        checks++;
        if ({CORE_RST, IN_READY} !== 2'b01) begin
            failures++;
            $display("FAIL reset_release: got core_rst,in_ready=%b want 01", {CORE_RST, IN_READY});
        end
    endtask

    // mode 0: IN_VALID always high, 1: toggles every other cycle, 2: random.
    task automatic send_frame(input int mode, input bit stale);
        int acc = 0;
        int cyc = 0;
        bit v;
        while (acc < NPTS && cyc < 2000) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = 1'($urandom);
            endcase
            IN_VALID = v; IN_X = px[acc]; IN_Y = py[acc];
            if (stale) begin
                CORE_DONE = 1'($urandom);
                {CORE_C1X, CORE_C1Y, CORE_C2X, CORE_C2Y} = 16'($urandom);
            end
            checks++;
            if ({IN_READY, OUT_VALID, BUSY} !== 3'b100) begin
                failures++;
                $display("FAIL collect_flags: point %0d got in_ready,out_valid,busy=%b want 100", acc, {IN_READY, OUT_VALID, BUSY});
            end
            if (v && IN_READY) acc++;
            tick;
            cyc++;
        end
        checks++;
        if (acc != NPTS) begin
            failures++;
            $display("FAIL collect_timeout: got %0d accepts want %0d", acc, NPTS);
        end
        // Keep offering data: the sequencer must refuse it now.
        IN_VALID = 1'b1; CORE_DONE = 1'b0;
        checks++;
        if ({IN_READY, CORE_RST, BUSY, OUT_VALID} !== 4'b0110) begin
            failures++;
            $display("FAIL frame_full: got in_ready,core_rst,busy,out_valid=%b want 0110", {IN_READY, CORE_RST, BUSY, OUT_VALID});
        end
    endtask

    task automatic check_stream(input int n);
        for (int k = 0; k < n; k++) begin
            tick;
            checks++;
            if ({CORE_RST, IN_READY, OUT_VALID, CORE_X, CORE_Y} !== {3'b000, px[k], py[k]}) begin
                failures++;
                $display("FAIL stream: point %0d got rst,rdy,vld=%b x=%0d y=%0d want 000 x=%0d y=%0d",
                         k, {CORE_RST, IN_READY, OUT_VALID}, CORE_X, CORE_Y, px[k], py[k]);
            end
        end
        if (n == NPTS) begin
            tick;
            IN_VALID = 1'b0;
            checks++;
            if ({CORE_X, CORE_Y, OUT_VALID, BUSY} !== {8'h00, 1'b0, 1'b1}) begin
                failures++;
                $display("FAIL stream_end: got x=%0d y=%0d vld=%b busy=%b want 0 0 0 1", CORE_X, CORE_Y, OUT_VALID, BUSY);
            end
        end
    endtask

    // Core model: assert DONE `delay` cycles into WAIT_DONE with result r.
    task automatic do_done(input int delay, input logic [15:0] r);
        for (int d = 0; d < delay; d++) begin
            {CORE_C1X, CORE_C1Y, CORE_C2X, CORE_C2Y} = 16'($urandom);
            checks++;
            if (OUT_VALID !== 1'b0) begin
                failures++;
                $display("FAIL early_valid: cycle %0d got %b want 0", d, OUT_VALID);
            end
            tick;
        end
        CORE_DONE = 1'b1;
        {CORE_C1X, CORE_C1Y, CORE_C2X, CORE_C2Y} = r;
        exp_res = r; exp_err = 1'b0;
        tick;
        CORE_DONE = 1'b0;
        {CORE_C1X, CORE_C1Y, CORE_C2X, CORE_C2Y} = ~r;
        checks++;
        if ({OUT_VALID, OUT_ERR, OUT_C1X, OUT_C1Y, OUT_C2X, OUT_C2Y} !== {1'b1, exp_err, exp_res}) begin
            failures++;
            $display("FAIL result: got vld=%b err=%b c=%h want 1 0 %h", OUT_VALID, OUT_ERR,
                     {OUT_C1X, OUT_C1Y, OUT_C2X, OUT_C2Y}, exp_res);
        end
    endtask

    task automatic accept_result(input int hold);
        for (int i = 0; i < hold; i++) begin
            OUT_READY = 1'b0;
            tick;
            checks++;
            if ({OUT_VALID, OUT_ERR, OUT_C1X, OUT_C1Y, OUT_C2X, OUT_C2Y, IN_READY, BUSY} !== {1'b1, exp_err, exp_res, 2'b01}) begin
                failures++;
                $display("FAIL backpressure: cycle %0d got vld=%b err=%b c=%h rdy=%b busy=%b want 1 %b %h 0 1",
                         i, OUT_VALID, OUT_ERR, {OUT_C1X, OUT_C1Y, OUT_C2X, OUT_C2Y}, IN_READY, BUSY, exp_err, exp_res);
            end
        end
        OUT_READY = 1'b1;
        tick;
        OUT_READY = 1'b0;
        checks++;
        if ({OUT_VALID, IN_READY, CORE_RST, BUSY} !== 4'b0110) begin
            failures++;
            $display("FAIL handshake: got vld,rdy,core_rst,busy=%b want 0110", {OUT_VALID, IN_READY, CORE_RST, BUSY});
        end
        tick;
        checks++;
        if ({CORE_RST, IN_READY, OUT_VALID} !== 3'b010) begin
            failures++;
            $display("FAIL park_pulse: got core_rst,rdy,vld=%b want 010", {CORE_RST, IN_READY, OUT_VALID});
        end
    endtask

    task automatic do_timeout;
        int n = 0;
        while (OUT_VALID !== 1'b1 && n < TIMEOUT * 4) begin
            {CORE_C1X, CORE_C1Y, CORE_C2X, CORE_C2Y} = 16'hFFFF;
            tick;
            n++;
        end
        exp_res = 16'h0000; exp_err = 1'b1;
        checks++;
        if (n != TIMEOUT) begin
            failures++;
            $display("FAIL timeout_latency: got %0d cycles want %0d", n, TIMEOUT);
        end
        checks++;
        if ({OUT_VALID, OUT_ERR, OUT_C1X, OUT_C1Y, OUT_C2X, OUT_C2Y} !== {2'b11, 16'h0000}) begin
            failures++;
            $display("FAIL timeout_result: got vld=%b err=%b c=%h want 1 1 0000", OUT_VALID, OUT_ERR,
                     {OUT_C1X, OUT_C1Y, OUT_C2X, OUT_C2Y});
        end
    endtask

    task automatic test_basic_frame;
        for (int k = 0; k < NPTS; k++) begin px[k] = 4'd5; py[k] = 4'd5; end
        send_frame(0, 1'b0);
        check_stream(NPTS);
        do_done(12, 16'h5151);
        accept_result(0);
    endtask

    task automatic test_gapped;
        for (int k = 0; k < NPTS; k++) begin px[k] = 4'(k % 16); py[k] = 4'(k / 16); end
        send_frame(1, 1'b0);
        check_stream(NPTS);
        do_done(int'($urandom_range(0, 40)), 16'($urandom));
        accept_result(0);
    endtask

    task automatic test_backpressure;
        random_frame();
        send_frame(2, 1'b0);
        check_stream(NPTS);
        do_done(int'($urandom_range(0, 40)), 16'($urandom));
        accept_result(100);
    endtask

    task automatic test_timeout;
        random_frame();
        send_frame(2, 1'b0);
        check_stream(NPTS);
        do_timeout();
        accept_result(3);
        // DONE on the very cycle the watchdog would fire.
        random_frame();
        send_frame(0, 1'b0);
        check_stream(NPTS);
        do_done(TIMEOUT - 1, 16'($urandom));
        accept_result(0);
    endtask

    task automatic test_reset_mid_stream;
        random_frame();
        send_frame(2, 1'b0);
        check_stream(21);
        RST = 1'b1;
        tick;
        RST = 1'b0;
        IN_VALID = 1'b0;
        checks++;
        if ({CORE_RST, IN_READY, OUT_VALID, BUSY, CORE_X, CORE_Y} !== {4'b1000, 8'h00}) begin
            failures++;
            $display("FAIL mid_reset: got rst,rdy,vld,busy=%b x=%0d y=%0d want 1000 0 0",
                     {CORE_RST, IN_READY, OUT_VALID, BUSY}, CORE_X, CORE_Y);
        end
        tick;
        for (int i = 0; i < 60; i++) begin
            CORE_DONE = 1'($urandom);
            checks++;
            if ({OUT_VALID, IN_READY, BUSY} !== 3'b010) begin
                failures++;
                $display("FAIL aborted_frame: cycle %0d got vld,rdy,busy=%b want 010", i, {OUT_VALID, IN_READY, BUSY});
            end
            tick;
        end
        CORE_DONE = 1'b0;
        random_frame();
        send_frame(2, 1'b0);
        check_stream(NPTS);
        do_done(int'($urandom_range(0, 40)), 16'($urandom));
        accept_result(0);
    endtask

    task automatic test_back_to_back;
        logic [15:0] first;
        random_frame();
        send_frame(0, 1'b0);
        check_stream(NPTS);
        first = 16'($urandom);
        do_done(int'($urandom_range(0, 40)), first);
        accept_result(0);
        random_frame();
        send_frame(2, 1'b1);
        check_stream(NPTS);
        do_done(int'($urandom_range(0, 40)), ~first);
        accept_result(0);
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_gapped();
        test_backpressure();
        test_timeout();
        test_reset_mid_stream();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
